// File: rtl/nn_rr_arbiter.sv
// Round-robin arbiter granting one requester at a time access to its cmem/dmem
// address lanes, with a bounded hold time while other requesters are waiting.
module nn_rr_lane_mux #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                     sel_vld,
  input  logic [$clog2(NREQ)-1:0]  sel,
  input  logic [NREQ-1:0][W-1:0]   lanes,
  output logic [W-1:0]             q
);
  assign q = sel_vld ? lanes[sel] : '0;
endmodule

module nn_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int NLANE   = 8,
  parameter int CAW     = 8,
  parameter int MAW     = 8,
  parameter int MAXHOLD = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ-1:0][NLANE-1:0][CAW-1:0]  cmem_addr_in,
  input  logic [NREQ-1:0][NLANE-1:0][MAW-1:0]  dmem_addr_in,
  output logic [NREQ-1:0]                      grant,
  output logic                                 grant_valid,
  output logic [$clog2(NREQ)-1:0]              grant_idx,
  output logic [NLANE-1:0][CAW-1:0]            cmem_addr,
  output logic [NLANE-1:0][MAW-1:0]            dmem_addr
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAXHOLD);
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_BUSY   = 1'b1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  logic [0:0]      r_state;
  logic [NREQ-1:0] r_grant;
  logic            r_vld;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_ptr;
  logic [HW-1:0]   r_hold;

  logic [NREQ-1:0] w_others;
  logic [NREQ-1:0] w_mask;
  logic            w_hold_req;
  logic            w_sat;
  logic            w_take;
  logic            w_found;
  logic [IW-1:0]   w_win;
  int              v_pos;

  assign w_others   = req & ~r_grant;
  assign w_hold_req = |(req & r_grant);
  assign w_sat      = (r_hold == HOLD_MAX);
  // In BUSY the holder is masked out, so a forced rotation never re-picks it.
  assign w_mask     = (r_state == S_IDLE) ? req : w_others;
  assign w_take     = (r_state == S_IDLE) ? (|req)
                                          : ((!w_hold_req || w_sat) && (|w_others));

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    v_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_pos = int'(r_ptr) + k;
      if (v_pos >= NREQ) v_pos = v_pos - NREQ;
      if (!w_found && w_mask[IW'(v_pos)]) begin
        w_found = 1'b1;
        w_win   = IW'(v_pos);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_vld   <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else if (w_take) begin
      r_state <= S_BUSY;
      r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
      r_vld   <= 1'b1;
      r_idx   <= w_win;
      r_ptr   <= (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
      r_hold  <= '0;
    end else if (r_state == S_BUSY) begin
      if (!w_hold_req) begin
        r_state <= S_IDLE;
        r_grant <= '0;
        r_vld   <= 1'b0;
        r_idx   <= '0;
      end else if (!w_sat) begin
        r_hold  <= r_hold + 1'b1;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_vld;
  assign grant_idx   = r_idx;

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    logic [NREQ-1:0][CAW-1:0] w_c;
    logic [NREQ-1:0][MAW-1:0] w_d;
    for (genvar r = 0; r < NREQ; r++) begin : g_req
      assign w_c[r] = cmem_addr_in[r][l];
      assign w_d[r] = dmem_addr_in[r][l];
    end
    nn_rr_lane_mux #(.NREQ(NREQ), .W(CAW)) u_cmux (
      .sel_vld (r_vld), .sel (r_idx), .lanes (w_c), .q (cmem_addr[l])
    );
    nn_rr_lane_mux #(.NREQ(NREQ), .W(MAW)) u_dmux (
      .sel_vld (r_vld), .sel (r_idx), .lanes (w_d), .q (dmem_addr[l])
    );
  end
endmodule
